// File: rtl/fp_instruction_decoder.sv
// -----------------------------------------------------------------------------
// fp_types_pkg
//   Encodings shared by the single-precision FP decode path: major opcodes,
//   sub-operation codes and the packed record of decoded fields.
//
// fp_instruction_decoder
//   Registered decoder for RV32F/RV64F single-precision instructions. Every
//   rising clk edge the instruction word present at that edge is decoded and
//   the result is registered; unrecognised or malformed words register as
//   all-zero, the same value reset produces.
//
// Ports
//   clk       in   1  clock, rising edge
//   rst       in   1  asynchronous, active-low reset
//   instr     in  32  instruction word
//   fp_op     out  7  major opcode, FP_OP_NONE when not an F instruction
//   func      out  7  FP_INSTR_* sub-op (NONE for loads, stores, R4, illegal)
//   fmt       out  2  format field for R4/OP-FP
//   rs1/rs2/rs3/rd    out 5  register indices
//   offset    out 12  load/store immediate
//   fp_read, fp_write, eff_read, eff_write, int_read, int_write  out 1 enables
//   rm        out  3  rounding mode
// -----------------------------------------------------------------------------
package fp_types_pkg;

  localparam logic [6:0] FP_OP_NONE   = 7'h00;
  localparam logic [6:0] FP_OP_FLW    = 7'b0000111;
  localparam logic [6:0] FP_OP_FSW    = 7'b0100111;
  localparam logic [6:0] FP_OP_FMADD  = 7'b1000011;
  localparam logic [6:0] FP_OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] FP_OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] FP_OP_FNMADD = 7'b1001111;
  localparam logic [6:0] FP_OP_OP_FP  = 7'b1010011;

  localparam logic [6:0] FP_INSTR_NONE      = 7'd0;
  localparam logic [6:0] FP_INSTR_FADD      = 7'd1;
  localparam logic [6:0] FP_INSTR_FSUB      = 7'd2;
  localparam logic [6:0] FP_INSTR_FMUL      = 7'd3;
  localparam logic [6:0] FP_INSTR_FDIV      = 7'd4;
  localparam logic [6:0] FP_INSTR_FSQRT     = 7'd5;
  localparam logic [6:0] FP_INSTR_FSGNJ     = 7'd6;
  localparam logic [6:0] FP_INSTR_FSGNJN    = 7'd7;
  localparam logic [6:0] FP_INSTR_FSGNJX    = 7'd8;
  localparam logic [6:0] FP_INSTR_FMIN      = 7'd9;
  localparam logic [6:0] FP_INSTR_FMAX      = 7'd10;
  localparam logic [6:0] FP_INSTR_FCVT_W_S  = 7'd11;
  localparam logic [6:0] FP_INSTR_FCVT_WU_S = 7'd12;
  localparam logic [6:0] FP_INSTR_FMV_X_W   = 7'd13;
  localparam logic [6:0] FP_INSTR_FEQ       = 7'd14;
  localparam logic [6:0] FP_INSTR_FLT       = 7'd15;
  localparam logic [6:0] FP_INSTR_FLE       = 7'd16;
  localparam logic [6:0] FP_INSTR_FCLASS    = 7'd17;
  localparam logic [6:0] FP_INSTR_FCVT_S_W  = 7'd18;
  localparam logic [6:0] FP_INSTR_FCVT_S_WU = 7'd19;
  localparam logic [6:0] FP_INSTR_FMV_W_X   = 7'd20;
  localparam logic [6:0] FP_INSTR_FCVT_L_S  = 7'd21;
  localparam logic [6:0] FP_INSTR_FCVT_LU_S = 7'd22;
  localparam logic [6:0] FP_INSTR_FCVT_S_L  = 7'd23;
  localparam logic [6:0] FP_INSTR_FCVT_S_LU = 7'd24;

  typedef struct packed {
    logic [6:0]  fp_op;
    logic [6:0]  func;
    logic [1:0]  fmt;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [4:0]  rd;
    logic [11:0] offset;
    logic        fp_read;
    logic        fp_write;
    logic        eff_read;
    logic        eff_write;
    logic        int_read;
    logic        int_write;
    logic [2:0]  rm;
  } fp_dec_t;

endpackage

module fp_instruction_decoder
  import fp_types_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [6:0]  fp_op,
  output logic [6:0]  func,
  output logic [1:0]  fmt,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rs3,
  output logic [4:0]  rd,
  output logic [11:0] offset,
  output logic        fp_read,
  output logic        fp_write,
  output logic        eff_read,
  output logic        eff_write,
  output logic        int_read,
  output logic        int_write,
  output logic [2:0]  rm
);

  logic [6:0] opcode_s;
  logic [4:0] rd_f_s;
  logic [2:0] funct3_s;
  logic [4:0] rs1_f_s;
  logic [4:0] rs2_f_s;
  logic [1:0] fmt_f_s;
  logic [4:0] funct5_s;

  fp_dec_t dec_s;
  fp_dec_t dec_r;
  logic    legal_s;

  assign opcode_s = instr[6:0];
  assign rd_f_s   = instr[11:7];
  assign funct3_s = instr[14:12];
  assign rs1_f_s  = instr[19:15];
  assign rs2_f_s  = instr[24:20];
  assign fmt_f_s  = instr[26:25];
  assign funct5_s = instr[31:27];

  // Combinational decode of the current word; legal_s gates whether it is kept.
  always_comb begin
    dec_s       = '0;
    dec_s.fp_op = FP_OP_NONE;
    dec_s.func  = FP_INSTR_NONE;
    legal_s     = 1'b0;
    case (opcode_s)
      FP_OP_FLW: begin
        // Width funct3 is deliberately not checked.
        legal_s        = 1'b1;
        dec_s.fp_op    = FP_OP_FLW;
        dec_s.rs1      = rs1_f_s;
        dec_s.rd       = rd_f_s;
        dec_s.offset   = instr[31:20];
        dec_s.fp_write = 1'b1;
        dec_s.eff_read = 1'b1;
      end
      FP_OP_FSW: begin
        legal_s         = 1'b1;
        dec_s.fp_op     = FP_OP_FSW;
        dec_s.rs1       = rs1_f_s;
        dec_s.rs2       = rs2_f_s;
        dec_s.offset    = {instr[31:25], instr[11:7]};
        dec_s.fp_read   = 1'b1;
        dec_s.eff_write = 1'b1;
      end
      FP_OP_FMADD, FP_OP_FMSUB, FP_OP_FNMSUB, FP_OP_FNMADD: begin
        // Only single precision (fmt 00) is supported; rm passes through.
        legal_s        = (fmt_f_s == 2'b00);
        dec_s.fp_op    = opcode_s;
        dec_s.fmt      = fmt_f_s;
        dec_s.rs1      = rs1_f_s;
        dec_s.rs2      = rs2_f_s;
        dec_s.rs3      = funct5_s;
        dec_s.rd       = rd_f_s;
        dec_s.rm       = funct3_s;
        dec_s.fp_read  = 1'b1;
        dec_s.fp_write = 1'b1;
      end
      FP_OP_OP_FP: begin
        dec_s.fp_op = FP_OP_OP_FP;
        dec_s.fmt   = fmt_f_s;
        dec_s.rs1   = rs1_f_s;
        dec_s.rd    = rd_f_s;
        case (funct5_s)
          5'b00000, 5'b00001, 5'b00010, 5'b00011: begin
            legal_s        = 1'b1;
            dec_s.func     = FP_INSTR_FADD + {5'b00000, funct5_s[1:0]};
            dec_s.rs2      = rs2_f_s;
            dec_s.rm       = funct3_s;
            dec_s.fp_read  = 1'b1;
            dec_s.fp_write = 1'b1;
          end
          5'b01011: begin
            legal_s        = (rs2_f_s == 5'd0);
            dec_s.func     = FP_INSTR_FSQRT;
            dec_s.rm       = funct3_s;
            dec_s.fp_read  = 1'b1;
            dec_s.fp_write = 1'b1;
          end
          5'b00100: begin
            dec_s.rs2      = rs2_f_s;
            dec_s.fp_read  = 1'b1;
            dec_s.fp_write = 1'b1;
            case (funct3_s)
              3'b000:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FSGNJ;  end
              3'b001:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FSGNJN; end
              3'b010:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FSGNJX; end
              default: legal_s = 1'b0;
            endcase
          end
          5'b00101: begin
            dec_s.rs2      = rs2_f_s;
            dec_s.fp_read  = 1'b1;
            dec_s.fp_write = 1'b1;
            case (funct3_s)
              3'b000:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FMIN; end
              3'b001:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FMAX; end
              default: legal_s = 1'b0;
            endcase
          end
          5'b10100: begin
            dec_s.rs2       = rs2_f_s;
            dec_s.fp_read   = 1'b1;
            dec_s.int_write = 1'b1;
            case (funct3_s)
              3'b010:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FEQ; end
              3'b001:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FLT; end
              3'b000:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FLE; end
              default: legal_s = 1'b0;
            endcase
          end
          5'b11000: begin
            // FP -> integer conversions; rs2 field picks the integer type.
            dec_s.rm        = funct3_s;
            dec_s.fp_read   = 1'b1;
            dec_s.int_write = 1'b1;
            case (rs2_f_s)
              5'd0:    begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCVT_W_S;  end
              5'd1:    begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCVT_WU_S; end
              5'd2:    begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCVT_L_S;  end
              5'd3:    begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCVT_LU_S; end
              default: legal_s = 1'b0;
            endcase
          end
          5'b11010: begin
            // Integer -> FP conversions; rs2 field picks the integer type.
            dec_s.rm       = funct3_s;
            dec_s.int_read = 1'b1;
            dec_s.fp_write = 1'b1;
            case (rs2_f_s)
              5'd0:    begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCVT_S_W;  end
              5'd1:    begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCVT_S_WU; end
              5'd2:    begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCVT_S_L;  end
              5'd3:    begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCVT_S_LU; end
              default: legal_s = 1'b0;
            endcase
          end
          5'b11100: begin
            dec_s.fp_read   = 1'b1;
            dec_s.int_write = 1'b1;
            if (rs2_f_s == 5'd0) begin
              case (funct3_s)
                3'b000:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FMV_X_W; end
                3'b001:  begin legal_s = 1'b1; dec_s.func = FP_INSTR_FCLASS;  end
                default: legal_s = 1'b0;
              endcase
            end else begin
              legal_s = 1'b0;
            end
          end
          5'b11110: begin
            legal_s        = (rs2_f_s == 5'd0) && (funct3_s == 3'b000);
            dec_s.func     = FP_INSTR_FMV_W_X;
            dec_s.int_read = 1'b1;
            dec_s.fp_write = 1'b1;
          end
          default: legal_s = 1'b0;
        endcase
        // Double/quad/half formats are not handled here.
        if (fmt_f_s != 2'b00) begin
          legal_s = 1'b0;
        end else begin
          legal_s = legal_s;
        end
      end
      default: legal_s = 1'b0;
    endcase
  end

  // Output register: illegal words register the reset (all-zero) value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_r <= '0;
    end else if (legal_s) begin
      dec_r <= dec_s;
    end else begin
      dec_r <= '0;
    end
  end

  assign fp_op     = dec_r.fp_op;
  assign func      = dec_r.func;
  assign fmt       = dec_r.fmt;
  assign rs1       = dec_r.rs1;
  assign rs2       = dec_r.rs2;
  assign rs3       = dec_r.rs3;
  assign rd        = dec_r.rd;
  assign offset    = dec_r.offset;
  assign fp_read   = dec_r.fp_read;
  assign fp_write  = dec_r.fp_write;
  assign eff_read  = dec_r.eff_read;
  assign eff_write = dec_r.eff_write;
  assign int_read  = dec_r.int_read;
  assign int_write = dec_r.int_write;
  assign rm        = dec_r.rm;

endmodule

// File: tb/tb_fp_instruction_decoder.sv
// -----------------------------------------------------------------------------
// Directed testbench for fp_instruction_decoder. Each step drives one
// instruction word and compares the whole registered output record against a
// hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_fp_instruction_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [6:0]  fp_op;
  logic [6:0]  func;
  logic [1:0]  fmt;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rs3;
  logic [4:0]  rd;
  logic [11:0] offset;
  logic        fp_read;
  logic        fp_write;
  logic        eff_read;
  logic        eff_write;
  logic        int_read;
  logic        int_write;
  logic [2:0]  rm;

  int vectors;
  int miscompares;

  localparam logic [6:0] OPFP = 7'b1010011;
  // Enable flag groups, order {fp_read, fp_write, eff_read, eff_write, int_read, int_write}
  localparam logic [5:0] FL_NONE = 6'b000000;
  localparam logic [5:0] FL_FF   = 6'b110000;
  localparam logic [5:0] FL_FI   = 6'b100001;
  localparam logic [5:0] FL_IF   = 6'b010010;
  localparam logic [5:0] FL_LD   = 6'b011000;
  localparam logic [5:0] FL_ST   = 6'b100100;
  localparam logic [56:0] ZERO   = 57'd0;

  fp_instruction_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .fp_op     (fp_op),
    .func      (func),
    .fmt       (fmt),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs3       (rs3),
    .rd        (rd),
    .offset    (offset),
    .fp_read   (fp_read),
    .fp_write  (fp_write),
    .eff_read  (eff_read),
    .eff_write (eff_write),
    .int_read  (int_read),
    .int_write (int_write),
    .rm        (rm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [56:0] ex(input logic [6:0] op, input logic [6:0] fn,
                                     input logic [4:0] r1, input logic [4:0] r2,
                                     input logic [4:0] r3, input logic [4:0] d,
                                     input logic [11:0] off, input logic [5:0] fl,
                                     input logic [2:0] rmv);
    return {op, fn, 2'b00, r1, r2, r3, d, off, fl, rmv};
  endfunction

  // Assemble an R-type word.
  function automatic logic [31:0] enc(input logic [4:0] f5, input logic [1:0] fm,
                                      input logic [4:0] r2, input logic [4:0] r1,
                                      input logic [2:0] f3, input logic [4:0] d,
                                      input logic [6:0] op);
    return {f5, fm, r2, r1, f3, d, op};
  endfunction

  task automatic check(input string tag, input logic [56:0] exp);
    logic [56:0] obs;
    obs = {fp_op, func, fmt, rs1, rs2, rs3, rd, offset,
           fp_read, fp_write, eff_read, eff_write, int_read, int_write, rm};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [31:0] w, input logic [56:0] exp);
    @(negedge clk);
    instr = w;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    instr       = 32'hFFFF_FFFF;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", ZERO);
    end

    @(negedge clk);
    rst = 1'b1;
    apply("release_zero_instr", 32'h0000_0000, ZERO);

    apply("flw",   32'hC93C_0B07, ex(7'b0000111, 7'd0, 5'd24, 5'd0, 5'd0, 5'd22, 12'hC93, FL_LD, 3'd0));
    apply("fsw",   32'hC96C_09A7, ex(7'b0100111, 7'd0, 5'd24, 5'd22, 5'd0, 5'd0, 12'hC93, FL_ST, 3'd0));
    apply("fmadd", 32'h916C_0743, ex(7'b1000011, 7'd0, 5'd24, 5'd22, 5'd18, 5'd14, 12'h000, FL_FF, 3'd0));
    apply("fadd",  32'h0020_F1D3, ex(OPFP, 7'd1, 5'd1, 5'd2, 5'd0, 5'd3, 12'h000, FL_FF, 3'b111));
    apply("fcvt_w_s", 32'hC002_9553, ex(OPFP, 7'd11, 5'd5, 5'd0, 5'd0, 5'd10, 12'h000, FL_FI, 3'b001));

    // Asynchronous reset between edges while FADD is registered.
    apply("fadd_again", 32'h0020_F1D3, ex(OPFP, 7'd1, 5'd1, 5'd2, 5'd0, 5'd3, 12'h000, FL_FF, 3'b111));
    #2;
    rst = 1'b0;
    #1;
    check("async_reset_clear", ZERO);
    @(posedge clk);
    #1;
    check("reset_low_edge", ZERO);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_release", ex(OPFP, 7'd1, 5'd1, 5'd2, 5'd0, 5'd3, 12'h000, FL_FF, 3'b111));

    apply("fsqrt", enc(5'b01011, 2'b00, 5'd0, 5'd7, 3'b010, 5'd9, OPFP),
          ex(OPFP, 7'd5, 5'd7, 5'd0, 5'd0, 5'd9, 12'h000, FL_FF, 3'b010));
    apply("fsqrt_rs2_bad", enc(5'b01011, 2'b00, 5'd1, 5'd7, 3'b010, 5'd9, OPFP), ZERO);
    apply("fdiv", enc(5'b00011, 2'b00, 5'd30, 5'd29, 3'b110, 5'd28, OPFP),
          ex(OPFP, 7'd4, 5'd29, 5'd30, 5'd0, 5'd28, 12'h000, FL_FF, 3'b110));
    apply("feq", enc(5'b10100, 2'b00, 5'd4, 5'd3, 3'b010, 5'd17, OPFP),
          ex(OPFP, 7'd14, 5'd3, 5'd4, 5'd0, 5'd17, 12'h000, FL_FI, 3'd0));
    apply("fle", enc(5'b10100, 2'b00, 5'd4, 5'd3, 3'b000, 5'd17, OPFP),
          ex(OPFP, 7'd16, 5'd3, 5'd4, 5'd0, 5'd17, 12'h000, FL_FI, 3'd0));
    apply("fcvt_s_wu", enc(5'b11010, 2'b00, 5'd1, 5'd12, 3'b100, 5'd6, OPFP),
          ex(OPFP, 7'd19, 5'd12, 5'd0, 5'd0, 5'd6, 12'h000, FL_IF, 3'b100));
    apply("fcvt_l_s", enc(5'b11000, 2'b00, 5'd2, 5'd8, 3'b011, 5'd20, OPFP),
          ex(OPFP, 7'd21, 5'd8, 5'd0, 5'd0, 5'd20, 12'h000, FL_FI, 3'b011));
    apply("fcvt_s_lu", enc(5'b11010, 2'b00, 5'd3, 5'd31, 3'b000, 5'd1, OPFP),
          ex(OPFP, 7'd24, 5'd31, 5'd0, 5'd0, 5'd1, 12'h000, FL_IF, 3'd0));
    apply("fcvt_rs2_bad", enc(5'b11000, 2'b00, 5'd4, 5'd8, 3'b011, 5'd20, OPFP), ZERO);
    apply("fmv_x_w", enc(5'b11100, 2'b00, 5'd0, 5'd2, 3'b000, 5'd5, OPFP),
          ex(OPFP, 7'd13, 5'd2, 5'd0, 5'd0, 5'd5, 12'h000, FL_FI, 3'd0));
    apply("fclass", enc(5'b11100, 2'b00, 5'd0, 5'd2, 3'b001, 5'd5, OPFP),
          ex(OPFP, 7'd17, 5'd2, 5'd0, 5'd0, 5'd5, 12'h000, FL_FI, 3'd0));
    apply("fmv_w_x", enc(5'b11110, 2'b00, 5'd0, 5'd10, 3'b000, 5'd11, OPFP),
          ex(OPFP, 7'd20, 5'd10, 5'd0, 5'd0, 5'd11, 12'h000, FL_IF, 3'd0));
    apply("fsgnjx", enc(5'b00100, 2'b00, 5'd5, 5'd6, 3'b010, 5'd7, OPFP),
          ex(OPFP, 7'd8, 5'd6, 5'd5, 5'd0, 5'd7, 12'h000, FL_FF, 3'd0));
    apply("fsgnj_f3_bad", enc(5'b00100, 2'b00, 5'd5, 5'd6, 3'b011, 5'd7, OPFP), ZERO);
    apply("fmax", enc(5'b00101, 2'b00, 5'd9, 5'd10, 3'b001, 5'd11, OPFP),
          ex(OPFP, 7'd10, 5'd10, 5'd9, 5'd0, 5'd11, 12'h000, FL_FF, 3'd0));
    apply("fadd_fmt_bad", enc(5'b00000, 2'b01, 5'd2, 5'd1, 3'b000, 5'd3, OPFP), ZERO);
    apply("fnmadd_rm101", {5'd3, 2'b00, 5'd2, 5'd1, 3'b101, 5'd4, 7'b1001111},
          ex(7'b1001111, 7'd0, 5'd1, 5'd2, 5'd3, 5'd4, 12'h000, FL_FF, 3'b101));
    apply("fmsub_fmt_bad", {5'd3, 2'b01, 5'd2, 5'd1, 3'b000, 5'd4, 7'b1000111}, ZERO);
    apply("int_op_illegal", enc(5'b00000, 2'b00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011), ZERO);
    apply("fsw_after_illegal", 32'hC96C_09A7,
          ex(7'b0100111, 7'd0, 5'd24, 5'd22, 5'd0, 5'd0, 12'hC93, FL_ST, 3'd0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
